escaneo_display: RTL and testbench
==================================

# escaneo_display

Parametrised multiplexed scanner for common-anode seven-segment displays. It replaces the fixed four-digit anode decoder, which needed an external refresh counter. The block owns its own refresh prescaler and takes a hex nibble per digit. It drives one digit at a time with a dead-time guard against ghosting, optional leading-zero blanking, a per-digit enable mask and per-digit decimal points. It sits between the Gray/binary/decimal conversion datapath and the board anode/segment pins.

## Interface
- N_DIGITOS, 4: number of digits scanned; must be ≥ 2.
- DIV_REFRESCO, 100000: clock cycles each digit stays selected; must be > T_GUARDA.
- T_GUARDA, 2: cycles at the start of each digit slot with all anodes off.
- ANODO_ACTIVO_BAJO, 1: 1 = active-low anodes, 0 = active-high. Segments and point are always active-low.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- datos  in  4·N_DIGITOS  hex nibble per digit; nibble i = datos[4i+3:4i]; digit 0 is rightmost.
- puntos  in  N_DIGITOS  decimal point request per digit (1 = lit).
- habilitar  in  N_DIGITOS  per-digit enable; 0 keeps that anode off for its whole slot.
- supr_ceros  in  1  1 = blank leading zeros.
- anodo  out  N_DIGITOS  anode drives.
- segmentos  out  7  {g,f,e,d,c,b,a}, active-low.
- punto  out  1  decimal point, active-low.
- digito_actual  out  $clog2(N_DIGITOS)  index of the slot currently scanned.
- tic  out  1  one-cycle pulse at each slot change.

## Operation
- Prescaler cnt runs 0..DIV_REFRESCO-1. When cnt = DIV_REFRESCO-1:
  - cnt returns to 0.
  - idx advances, wrapping from N_DIGITOS-1 to 0.
- Frame snapshot captures all of datos into an internal register:
  - while rst = 1;
  - when cnt = DIV_REFRESCO-1 and idx = N_DIGITOS-1.
  - Between captures, the display is driven only from the snapshot. Changes to datos mid-frame never tear a frame.
- puntos, habilitar and supr_ceros are not snapshotted; they are sampled live each cycle.
- Guard: while cnt < T_GUARDA, all anodes are off, segmentos = 7'h7F and punto = 1.
- Outside the guard:
  - If habilitar[idx] = 1, only anodo[idx] is active.
  - If habilitar[idx] = 0, all anodes are off.
- Blanking: digit i (i ≥ 1) is blank when supr_ceros = 1 and snapshot nibbles i..N_DIGITOS-1 are all zero.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - A blank digit keeps its anode active but drives segmentos = 7'h7F.
  - A blank digit still honours puntos.
- Hex decode, active-low {g..a}: 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19, 5 = 12, 6 = 02, 7 = 78, 8 = 00, 9 = 10, A = 08, b = 03, C = 46, d = 21, E = 06, F = 0E.
- punto = ~puntos[idx] outside the guard.
- Anode polarity: "off" is all-ones when ANODO_ACTIVO_BAJO = 1, all-zeros when 0. "Active" is the complement of "off".

## Timing
- Reset values:
  - cnt = 0, idx = 0, digito_actual = 0, tic = 0.
  - anodo = off.
  - segmentos = 7'h7F, punto = 1.
  - Snapshot = datos as sampled during reset.
- anodo, segmentos, punto and tic are registered. Each is computed from cnt/idx/snapshot of the previous cycle, giving 1-cycle latency.
- digito_actual equals idx with no extra delay.
- tic is 1 in the cycle after the edge where cnt wrapped, coincident with the new digito_actual.
- Per slot, at the outputs: T_GUARDA cycles with all anodes off, then DIV_REFRESCO − T_GUARDA cycles with the digit driven.
- Frame period: N_DIGITOS·DIV_REFRESCO cycles.
- Reset asserted mid-slot: all of the above return to reset values on the next edge; the scan restarts at digit 0 with the guard.
- Changes to habilitar, puntos or supr_ceros take effect at the outputs 1 cycle after they change.

## Test plan
Unless stated, all scenarios use N_DIGITOS = 4, DIV_REFRESCO = 4, T_GUARDA = 1, active-low anodes, habilitar = 4'hF. Edge 0 is the first edge with rst = 0.
- Basic scan, datos = 16'h1234, puntos = 0, supr_ceros = 0:
  - After edge 0: anodo = 1111.
  - Edges 1–3: anodo = 1110, segmentos = 7'h19.
  - Edge 4: tic = 1, all anodes off.
  - Edges 5–7: anodo = 1101, segmentos = 7'h30.
  - Remaining slots: 2 = 7'h24, then 1 = 7'h79, then wrap to 1110.
- Leading zeros, datos = 16'h0050, supr_ceros = 1:
  - Digits 3 and 2 keep their anodes active with segmentos 7'h7F.
  - Digit 1 = 7'h12, digit 0 = 7'h40.
  - Repeat with datos = 0: only digit 0 shows 7'h40.
- Mid-frame data change: set datos from 16'h1111 to 16'h8888 during the digit-1 slot.
  - Digits 2 and 3 of the current frame still show 7'h79.
  - The next frame shows 7'h00 on all digits.
- Mask and points: habilitar = 4'b1011, puntos = 4'b0001.
  - Digit 2 anode stays off for its entire slot.
  - punto = 0 only while digit 0 is driven.
- Reset mid-slot: assert rst for 1 cycle at cnt = 2, idx = 2.
  - Next cycle: anodo = 1111, digito_actual = 0, tic = 0.
  - The sequence then replays the first scenario timing.
- Parameter sweep: N_DIGITOS = 8, DIV_REFRESCO = 3, T_GUARDA = 0, ANODO_ACTIVO_BAJO = 0.
  - One-hot active-high anodes 00000001 → 10000000 → 00000001.
  - Each anode lasts 3 cycles, with no all-off cycles.

Source files
------------

// File: rtl/escaneo_display.sv
// Multiplexed scanner for common-anode seven-segment displays: own refresh prescaler, per-frame
// data snapshot, dead-time guard, leading-zero blanking, digit mask and decimal points.
module escaneo_display #(
  parameter int unsigned N_DIGITOS         = 4,
  parameter int unsigned DIV_REFRESCO      = 100000,
  parameter int unsigned T_GUARDA          = 2,
  parameter bit          ANODO_ACTIVO_BAJO = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [4*N_DIGITOS-1:0]       datos,
  input  logic [N_DIGITOS-1:0]         puntos,
  input  logic [N_DIGITOS-1:0]         habilitar,
  input  logic                         supr_ceros,
  output logic [N_DIGITOS-1:0]         anodo,
  output logic [6:0]                   segmentos,
  output logic                         punto,
  output logic [$clog2(N_DIGITOS)-1:0] digito_actual,
  output logic                         tic
);

  localparam int unsigned IW = $clog2(N_DIGITOS);
  localparam int unsigned CW = (DIV_REFRESCO > 1) ? $clog2(DIV_REFRESCO) : 1;

  localparam logic [CW-1:0]        CNT_MAX   = CW'(DIV_REFRESCO - 1);
  localparam logic [IW-1:0]        IDX_MAX   = IW'(N_DIGITOS - 1);
  localparam logic [N_DIGITOS-1:0] ANODO_OFF = {N_DIGITOS{ANODO_ACTIVO_BAJO}};
  localparam logic [6:0]           SEG_OFF   = 7'h7F;

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [4*N_DIGITOS-1:0] snap_q, snap_d;
  logic [N_DIGITOS-1:0]   anodo_q, anodo_d;
  logic [6:0]             seg_q, seg_d;
  logic                   punto_q, punto_d;
  logic                   tic_q, tic_d;

  logic                   en_guarda;
  logic [N_DIGITOS-1:0]   cero_arriba;
  logic                   acum_cero;
  logic [3:0]             nibble;
  logic                   blanco;
  logic [N_DIGITOS-1:0]   uno_caliente;

  function automatic logic [6:0] hex_a_7seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  if (T_GUARDA == 0) begin : g_sin_guarda
    assign en_guarda = 1'b0;
  end else begin : g_guarda
    assign en_guarda = (cnt_q < CW'(T_GUARDA));
  end

  // cero_arriba[i]: snapshot nibbles i..N_DIGITOS-1 are all zero
  always_comb begin
    cero_arriba = '0;
    acum_cero   = 1'b1;
    for (int i = N_DIGITOS - 1; i >= 0; i--) begin
      acum_cero      = acum_cero & (snap_q[4*i +: 4] == 4'h0);
      cero_arriba[i] = acum_cero;
    end
  end

  assign nibble       = snap_q[4*idx_q +: 4];
  assign blanco       = supr_ceros && (idx_q != '0) && cero_arriba[idx_q];
  assign uno_caliente = N_DIGITOS'(1) << idx_q;

  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    idx_d  = idx_q;
    snap_d = snap_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      if (idx_q == IDX_MAX) begin
        idx_d  = '0;
        snap_d = datos;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_comb begin
    anodo_d = ANODO_OFF;
    seg_d   = SEG_OFF;
    punto_d = 1'b1;
    // Pulses alongside the first output cycle of each new slot
    tic_d   = (cnt_q == '0);
    if (!en_guarda) begin
      punto_d = ~puntos[idx_q];
      seg_d   = blanco ? SEG_OFF : hex_a_7seg(nibble);
      if (habilitar[idx_q]) begin
        anodo_d = ANODO_OFF ^ uno_caliente;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      snap_q  <= datos;
      anodo_q <= ANODO_OFF;
      seg_q   <= SEG_OFF;
      punto_q <= 1'b1;
      tic_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      anodo_q <= anodo_d;
      seg_q   <= seg_d;
      punto_q <= punto_d;
      tic_q   <= tic_d;
    end
  end

  assign anodo         = anodo_q;
  assign segmentos     = seg_q;
  assign punto         = punto_q;
  assign tic           = tic_q;
  assign digito_actual = idx_q;

endmodule

// File: tb/tb_escaneo_display.sv
// Scoreboard bench for escaneo_display: a 4-digit active-low instance and an 8-digit
// active-high, guard-free instance, checked cycle by cycle against hand-computed vectors.
module tb_escaneo_display;

  logic        clk = 1'b0;
  logic        rst_a = 1'b1;
  logic        rst_b = 1'b1;
  logic [15:0] datos_a = 16'h0;
  logic [3:0]  puntos_a = 4'h0;
  logic [3:0]  hab_a = 4'hF;
  logic        supr_a = 1'b0;
  logic [3:0]  anodo_a;
  logic [6:0]  seg_a;
  logic        punto_a;
  logic [1:0]  dig_a;
  logic        tic_a;

  logic [31:0] datos_b = 32'h7654_3210;
  logic [7:0]  anodo_b;
  logic [6:0]  seg_b;
  logic        punto_b;
  logic [2:0]  dig_b;
  logic        tic_b;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          c;
    string       nm;
    bit          b;
    logic [7:0]  an;
    int          seg;
    int          pt;
    int          tc;
    int          dig;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  escaneo_display #(
    .N_DIGITOS(4), .DIV_REFRESCO(4), .T_GUARDA(1), .ANODO_ACTIVO_BAJO(1'b1)
  ) u_dut_a (
    .clk(clk), .rst(rst_a), .datos(datos_a), .puntos(puntos_a), .habilitar(hab_a),
    .supr_ceros(supr_a), .anodo(anodo_a), .segmentos(seg_a), .punto(punto_a),
    .digito_actual(dig_a), .tic(tic_a)
  );

  escaneo_display #(
    .N_DIGITOS(8), .DIV_REFRESCO(3), .T_GUARDA(0), .ANODO_ACTIVO_BAJO(1'b0)
  ) u_dut_b (
    .clk(clk), .rst(rst_b), .datos(datos_b), .puntos(8'h00), .habilitar(8'hFF),
    .supr_ceros(1'b0), .anodo(anodo_b), .segmentos(seg_b), .punto(punto_b),
    .digito_actual(dig_b), .tic(tic_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops every entry due this cycle and compares on the falling edge
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].c <= cyc) begin
      logic [7:0] a_an;
      logic [6:0] a_seg;
      logic       a_pt;
      logic       a_tc;
      int         a_dig;
      e     = sb.pop_front();
      a_an  = e.b ? anodo_b : {4'h0, anodo_a};
      a_seg = e.b ? seg_b : seg_a;
      a_pt  = e.b ? punto_b : punto_a;
      a_tc  = e.b ? tic_b : tic_a;
      a_dig = e.b ? int'(dig_b) : int'(dig_a);
      checks++;
      if (e.c < cyc) begin
        errors++;
        $display("FAIL %s: entry for cycle %0d reached monitor at cycle %0d", e.nm, e.c, cyc);
      end else if (a_an !== e.an) begin
        errors++;
        $display("FAIL %s anodo: got %b want %b", e.nm, a_an, e.an);
      end
      if (e.seg >= 0) begin
        checks++;
        if (a_seg !== 7'(e.seg)) begin
          errors++;
          $display("FAIL %s segmentos: got %h want %h", e.nm, a_seg, 7'(e.seg));
        end
      end
      if (e.pt >= 0) begin
        checks++;
        if (a_pt !== 1'(e.pt)) begin
          errors++;
          $display("FAIL %s punto: got %b want %0d", e.nm, a_pt, e.pt);
        end
      end
      if (e.tc >= 0) begin
        checks++;
        if (a_tc !== 1'(e.tc)) begin
          errors++;
          $display("FAIL %s tic: got %b want %0d", e.nm, a_tc, e.tc);
        end
      end
      if (e.dig >= 0) begin
        checks++;
        if (a_dig != e.dig) begin
          errors++;
          $display("FAIL %s digito_actual: got %0d want %0d", e.nm, a_dig, e.dig);
        end
      end
    end
  end

  task automatic push(input int c, input string nm, input bit b, input logic [7:0] an,
                      input int seg, input int pt, input int tc, input int dig);
    exp_t x;
    x.c = c; x.nm = nm; x.b = b; x.an = an; x.seg = seg; x.pt = pt; x.tc = tc; x.dig = dig;
    sb.push_back(x);
  endtask

  // One 4-cycle slot of instance A: guard cycle then three driven cycles
  task automatic slot_a(input int e0, input int s, input string nm, input logic [3:0] an,
                        input int seg, input int pt);
    int k;
    k = 4 * s;
    push(e0 + k, $sformatf("%s s%0d guard", nm, s), 1'b0, 8'h0F, 'h7F, 1,
         (s > 0) ? 1 : -1, s % 4);
    for (int j = 1; j <= 3; j++) begin
      k = 4 * s + j;
      push(e0 + k, $sformatf("%s s%0d k%0d", nm, s, k), 1'b0, {4'h0, an}, seg, pt, 0,
           ((k + 1) / 4) % 4);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_a(input logic [15:0] d, output int e0);
    @(posedge clk);
    #1;
    rst_a   = 1'b1;
    datos_a = d;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    e0    = cyc + 1;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (sb.size() > 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s drain: %0d entries left, want 0", nm, sb.size());
      sb.delete();
    end
  endtask

  logic [6:0] tab_b [8];
  int e0;
  int e1;

  initial begin
    tab_b = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};

    // Basic scan
    reset_a(16'h1234, e0);
    push(e0, "scan k0", 1'b0, 8'h0F, 'h7F, 1, -1, 0);
    slot_a(e0, 1, "scan", 4'hD, 'h30, 1);
    slot_a(e0, 2, "scan", 4'hB, 'h24, 1);
    slot_a(e0, 3, "scan", 4'h7, 'h79, 1);
    slot_a(e0, 4, "scan", 4'hE, 'h19, 1);
    drain("scan");
    reset_a(16'h1234, e0);
    slot_a(e0, 0, "scan0", 4'hE, 'h19, 1);
    drain("scan0");

    // Leading zero blanking
    supr_a = 1'b1;
    reset_a(16'h0050, e0);
    slot_a(e0, 0, "lz50", 4'hE, 'h40, 1);
    slot_a(e0, 1, "lz50", 4'hD, 'h12, 1);
    slot_a(e0, 2, "lz50", 4'hB, 'h7F, 1);
    slot_a(e0, 3, "lz50", 4'h7, 'h7F, 1);
    drain("lz50");
    reset_a(16'h0000, e0);
    slot_a(e0, 0, "lz0", 4'hE, 'h40, 1);
    slot_a(e0, 1, "lz0", 4'hD, 'h7F, 1);
    slot_a(e0, 2, "lz0", 4'hB, 'h7F, 1);
    slot_a(e0, 3, "lz0", 4'h7, 'h7F, 1);
    drain("lz0");
    supr_a = 1'b0;

    // Mid-frame data change must not tear the frame
    reset_a(16'h1111, e0);
    for (int s = 0; s < 4; s++) slot_a(e0, s, "tear old", 4'hF ^ (4'h1 << s), 'h79, 1);
    for (int s = 4; s < 8; s++) slot_a(e0, s, "tear new", 4'hF ^ (4'h1 << (s - 4)), 'h00, 1);
    wait_cyc(e0 + 5);
    datos_a = 16'h8888;
    drain("tear");

    // Enable mask and decimal points
    hab_a    = 4'b1011;
    puntos_a = 4'b0001;
    reset_a(16'h1234, e0);
    slot_a(e0, 0, "mask", 4'hE, 'h19, 0);
    slot_a(e0, 1, "mask", 4'hD, 'h30, 1);
    slot_a(e0, 2, "mask", 4'hF, -1, 1);
    slot_a(e0, 3, "mask", 4'h7, 'h79, 1);
    drain("mask");
    hab_a    = 4'hF;
    puntos_a = 4'h0;

    // Reset asserted mid-slot at cnt=2, idx=2
    reset_a(16'h1234, e0);
    e1 = e0 + 11;
    slot_a(e0, 0, "mrst pre", 4'hE, 'h19, 1);
    slot_a(e0, 1, "mrst pre", 4'hD, 'h30, 1);
    push(e0 + 8, "mrst k8", 1'b0, 8'h0F, 'h7F, 1, 1, 2);
    push(e0 + 9, "mrst k9", 1'b0, 8'h0B, 'h24, 1, 0, 2);
    push(e0 + 10, "mrst rst", 1'b0, 8'h0F, 'h7F, 1, 0, 0);
    push(e1, "mrst re k0", 1'b0, 8'h0F, 'h7F, 1, -1, 0);
    slot_a(e1, 1, "mrst re", 4'hD, 'h30, 1);
    slot_a(e1, 2, "mrst re", 4'hB, 'h24, 1);
    slot_a(e1, 3, "mrst re", 4'h7, 'h79, 1);
    slot_a(e1, 4, "mrst re", 4'hE, 'h19, 1);
    wait_cyc(e0 + 9);
    rst_a = 1'b1;
    wait_cyc(e0 + 10);
    rst_a = 1'b0;
    drain("mrst");

    // 8 digits, no guard, active-high anodes
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    e0    = cyc + 1;
    for (int k = 0; k < 27; k++) begin
      push(e0 + k, $sformatf("sweep k%0d", k), 1'b1, 8'h01 << ((k / 3) % 8),
           int'(tab_b[(k / 3) % 8]), 1, (k == 0) ? -1 : ((k % 3 == 0) ? 1 : 0),
           ((k + 1) / 3) % 8);
    end
    drain("sweep");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d entries pending", sb.size());
    $fatal(1, "watchdog");
  end

endmodule
